// File: rtl/div_pkg.sv
// Shared constants for the divider and the multiply/divide op decode.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

    // FSM state encoding for the divider
    typedef logic [2:0] div_state_t;
    localparam div_state_t ST_IDLE  = 3'd0;
    localparam div_state_t ST_PREP  = 3'd1;
    localparam div_state_t ST_LOOP  = 3'd2;
    localparam div_state_t ST_FIX   = 3'd3;
    localparam div_state_t ST_EARLY = 3'd4;

    // op field bit positions
    localparam int DIV_OP_REM_BIT = 1;
    localparam int DIV_OP_UNS_BIT = 0;

    // op encoding shared with the multiplier decode
    localparam int         MD_OP_W    = 2;
    localparam logic [1:0] MD_OP_DIV  = 2'b00;
    localparam logic [1:0] MD_OP_DIVU = 2'b01;
    localparam logic [1:0] MD_OP_REM  = 2'b10;
    localparam logic [1:0] MD_OP_REMU = 2'b11;

endpackage

// File: rtl/div_rest_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
module div_rest_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_r,   // partial remainder
    input  logic [WIDTH-1:0] i_q,   // quotient / remaining dividend bits
    input  logic [WIDTH-1:0] i_d,   // divisor magnitude
    output logic [WIDTH-1:0] o_r,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   w_trial;
    logic [WIDTH+1:0] w_diff;
    logic             w_neg;
    logic             w_unused_diff_msb;

    // The trial value is always < 2*D, so WIDTH+1 bits hold it; the extra top bit is the borrow.
    assign w_trial           = {i_r, i_q[WIDTH-1]};
    assign w_diff            = {1'b0, w_trial} - {2'b00, i_d};
    assign w_neg             = w_diff[WIDTH+1];
    assign w_unused_diff_msb = w_diff[WIDTH];

    // Restore on borrow: keep the shifted remainder (it is < D, so it fits WIDTH bits).
    assign o_r = w_neg ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_q = {i_q[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/div_rest_param.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU; optional early-out via DIV_EARLY_OUT_EN.
// Latency: WIDTH+2 cycles start->done (1 cycle on early-out when DIV_EARLY_OUT_EN is defined).
// Backpressure: busy=1 while working; start_in is ignored (not queued) until busy drops.
module div_rest_param
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstLow,
    input  logic             start_in,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a, r_b;      // original operands, needed for the dbz result
    logic             r_uns;
    logic             r_sq, r_sr;    // quotient / remainder negate flags
    logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
    logic [WIDTH-1:0] r_q, r_r;
    logic             r_dbz, r_done;

    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;
    logic             w_unused_op;

    // op[1] only selects which result the core consumes; both are always produced.
    assign w_unused_op = op_in[DIV_OP_REM_BIT];

    // Operand magnitudes from the latched operands, used in PREP.
    assign w_a_mag = (!r_uns && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_b_mag = (!r_uns && r_b[WIDTH-1]) ? -r_b : r_b;

`ifdef DIV_EARLY_OUT_EN
    logic             w_in_sgn;
    logic [WIDTH-1:0] w_in_amag, w_in_bmag;
    logic             w_early;

    // Trivial cases decided straight from the inputs: divide by zero, or |a| < |b|.
    assign w_in_sgn  = ~op_in[DIV_OP_UNS_BIT];
    assign w_in_amag = (w_in_sgn && a_in[WIDTH-1]) ? -a_in : a_in;
    assign w_in_bmag = (w_in_sgn && b_in[WIDTH-1]) ? -b_in : b_in;
    assign w_early   = (b_in == '0) || (w_in_amag < w_in_bmag);
`endif

    div_rest_step #(.WIDTH(WIDTH)) u_step (
        .i_r (r_rem),
        .i_q (r_quo),
        .i_d (r_dvs),
        .o_r (w_rem_nxt),
        .o_q (w_quo_nxt)
    );

    // Control FSM, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_uns   <= 1'b0;
            r_sq    <= 1'b0;
            r_sr    <= 1'b0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        r_a   <= a_in;
                        r_b   <= b_in;
                        r_uns <= op_in[DIV_OP_UNS_BIT];
`ifdef DIV_EARLY_OUT_EN
                        r_state <= w_early ? ST_EARLY : ST_PREP;
`else
                        r_state <= ST_PREP;
`endif
                    end
                end
                ST_PREP: begin
                    r_sq    <= ~r_uns & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_sr    <= ~r_uns & r_a[WIDTH-1];
                    r_rem   <= '0;
                    r_quo   <= w_a_mag;
                    r_dvs   <= w_b_mag;
                    r_cnt   <= '0;
                    r_state <= ST_LOOP;
                end
                ST_LOOP: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (r_b == '0) begin
                        r_q   <= '1;
                        r_r   <= r_a;
                        r_dbz <= 1'b1;
                    end else begin
                        r_q   <= r_sq ? -r_quo : r_quo;
                        r_r   <= r_sr ? -r_rem : r_rem;
                        r_dbz <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
`ifdef DIV_EARLY_OUT_EN
                ST_EARLY: begin
                    r_q     <= (r_b == '0) ? '1 : '0;
                    r_r     <= r_a;
                    r_dbz   <= (r_b == '0);
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (r_state != ST_IDLE);
    assign done  = r_done;
    assign dbz   = r_dbz;
    assign q_out = r_q;
    assign r_out = r_r;

endmodule

// File: tb/tb_div_rest_param.sv
// Directed bench for div_rest_param at WIDTH=32.
// Latency: n/a.
// Backpressure: n/a.
module tb_div_rest_param;

    localparam int W = 32;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         start_in = 1'b0;
    logic [1:0]   op_in    = 2'b00;
    logic [W-1:0] a_in     = '0;
    logic [W-1:0] b_in     = '0;
    logic         busy, done, dbz;
    logic [W-1:0] q_out, r_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_rest_param #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstLow   (rst_n),
        .start_in (start_in),
        .op_in    (op_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .dbz      (dbz),
        .q_out    (q_out),
        .r_out    (r_out)
    );

    // Issue one op (call between edges), scramble inputs after the start edge, wait for done.
    // lat = number of cycles after the start edge until done is seen; bcyc = busy cycles seen.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcyc, output bit ok);
        start_in = 1'b1; op_in = op; a_in = a; b_in = b;
        @(posedge clk); #1;
        start_in = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        op_in = 2'($urandom_range(0, 3));
        lat = 0; bcyc = 0; ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (done) begin
                lat = k;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL rst_dbz: got %b want 0", dbz); end
        n_checks++; if (q_out !== 32'h0) begin n_fail++; $display("FAIL rst_q: got %h want 0", q_out); end
        n_checks++; if (r_out !== 32'h0) begin n_fail++; $display("FAIL rst_r: got %h want 0", r_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_divu_latency();
        int lat, bcyc; bit ok;
        issue(2'b01, 32'd100, 32'd7, lat, bcyc, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL divu_timeout: no done within 100 cycles"); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL divu_latency: got %0d want 34", lat); end
        n_checks++; if (bcyc != 34) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d want 34", bcyc); end
        n_checks++; if (q_out !== 32'd14) begin n_fail++; $display("FAIL divu_q: got %h want %h", q_out, 32'd14); end
        n_checks++; if (r_out !== 32'd2) begin n_fail++; $display("FAIL divu_r: got %h want %h", r_out, 32'd2); end
        n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL divu_dbz: got %b want 0", dbz); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL divu_done_pulse: got %b want 0", done); end
        // results hold while inputs wander with no start
        a_in = 32'h1234; b_in = 32'h5;
        repeat (4) @(negedge clk);
        n_checks++; if (q_out !== 32'd14 || r_out !== 32'd2) begin
            n_fail++; $display("FAIL hold_results: got q=%h r=%h want q=%h r=%h", q_out, r_out, 32'd14, 32'd2);
        end
        // large unsigned dividend
        issue(2'b11, 32'hFFFFFFFF, 32'h10, lat, bcyc, ok);
        n_checks++; if (!ok || q_out !== 32'h0FFFFFFF || r_out !== 32'hF) begin
            n_fail++; $display("FAIL remu_big: ok=%0d got q=%h r=%h want q=0fffffff r=0000000f", ok, q_out, r_out);
        end
    endtask

    task automatic test_signed();
        int lat, bcyc; bit ok;
        issue(2'b00, 32'hFFFFFFF9, 32'd2, lat, bcyc, ok);
        n_checks++; if (!ok || q_out !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_m7_2_q: got %h want fffffffd", q_out); end
        n_checks++; if (r_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_m7_2_r: got %h want ffffffff", r_out); end
        issue(2'b10, 32'd7, 32'hFFFFFFFE, lat, bcyc, ok);
        n_checks++; if (!ok || q_out !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_7_m2_q: got %h want fffffffd", q_out); end
        n_checks++; if (r_out !== 32'd1) begin n_fail++; $display("FAIL div_7_m2_r: got %h want 00000001", r_out); end
    endtask

    task automatic test_overflow();
        int lat, bcyc; bit ok;
        issue(2'b00, 32'h80000000, 32'hFFFFFFFF, lat, bcyc, ok);
        n_checks++; if (!ok || q_out !== 32'h80000000) begin n_fail++; $display("FAIL ovf_q: got %h want 80000000", q_out); end
        n_checks++; if (r_out !== 32'h0) begin n_fail++; $display("FAIL ovf_r: got %h want 0", r_out); end
        n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL ovf_dbz: got %b want 0", dbz); end
    endtask

    task automatic test_div_by_zero();
        int lat, bcyc; bit ok;
        issue(2'b01, 32'd5, 32'd0, lat, bcyc, ok);
        n_checks++; if (!ok || q_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dbz_u_q: got %h want ffffffff", q_out); end
        n_checks++; if (r_out !== 32'd5) begin n_fail++; $display("FAIL dbz_u_r: got %h want 00000005", r_out); end
        n_checks++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_u_flag: got %b want 1", dbz); end
        issue(2'b00, 32'hFFFFFFFB, 32'd0, lat, bcyc, ok);
        n_checks++; if (!ok || q_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dbz_s_q: got %h want ffffffff", q_out); end
        n_checks++; if (r_out !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL dbz_s_r: got %h want fffffffb", r_out); end
        n_checks++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_s_flag: got %b want 1", dbz); end
        // a normal op afterwards clears the flag
        issue(2'b01, 32'd9, 32'd2, lat, bcyc, ok);
        n_checks++; if (!ok || dbz !== 1'b0 || q_out !== 32'd4 || r_out !== 32'd1) begin
            n_fail++; $display("FAIL dbz_clear: got dbz=%b q=%h r=%h want dbz=0 q=00000004 r=00000001", dbz, q_out, r_out);
        end
    endtask

    task automatic test_reset_mid_loop();
        int lat, bcyc; bit ok;
        start_in = 1'b1; op_in = 2'b01; a_in = 32'd100; b_in = 32'd7;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midloop_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midloop_busy: got %b want 0", busy); end
        n_checks++; if (q_out !== 32'h0 || r_out !== 32'h0) begin
            n_fail++; $display("FAIL midloop_outputs: got q=%h r=%h want 0 0", q_out, r_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b01, 32'd9, 32'd3, lat, bcyc, ok);
        n_checks++; if (!ok || lat != 34) begin n_fail++; $display("FAIL after_reset_latency: ok=%0d got %0d want 34", ok, lat); end
        n_checks++; if (q_out !== 32'd3 || r_out !== 32'd0) begin
            n_fail++; $display("FAIL after_reset_result: got q=%h r=%h want 00000003 00000000", q_out, r_out);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcyc; bit ok;
        // start held high during busy with other operands must not disturb the running op
        start_in = 1'b1; op_in = 2'b01; a_in = 32'd1000; b_in = 32'd9;
        @(posedge clk); #1;
        a_in = 32'd50; b_in = 32'd5;
        lat = 0; ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 20) start_in = 1'b0;
            if (done) begin
                lat = k;
                ok  = 1'b1;
                break;
            end
        end
        n_checks++; if (!ok || lat != 34) begin n_fail++; $display("FAIL ignore_latency: ok=%0d got %0d want 34", ok, lat); end
        n_checks++; if (q_out !== 32'd111 || r_out !== 32'd1) begin
            n_fail++; $display("FAIL ignore_result: got q=%h r=%h want 0000006f 00000001", q_out, r_out);
        end
        // issue in the done cycle
        issue(2'b00, 32'hFFFFFF9C, 32'd7, lat, bcyc, ok);
        n_checks++; if (!ok || lat != 34 || bcyc != 34) begin
            n_fail++; $display("FAIL b2b_timing: ok=%0d lat=%0d busy=%0d want 34 34", ok, lat, bcyc);
        end
        n_checks++; if (q_out !== 32'hFFFFFFF2 || r_out !== 32'hFFFFFFFE) begin
            n_fail++; $display("FAIL b2b_result: got q=%h r=%h want fffffff2 fffffffe", q_out, r_out);
        end
    endtask

`ifdef DIV_EARLY_OUT_EN
    task automatic test_early();
        int lat, bcyc; bit ok;
        issue(2'b01, 32'd3, 32'd10, lat, bcyc, ok);
        n_checks++; if (!ok || lat != 1 || bcyc != 1) begin
            n_fail++; $display("FAIL early_timing: ok=%0d lat=%0d busy=%0d want 1 1", ok, lat, bcyc);
        end
        n_checks++; if (q_out !== 32'd0 || r_out !== 32'd3 || dbz !== 1'b0) begin
            n_fail++; $display("FAIL early_result: got q=%h r=%h dbz=%b want 0 3 0", q_out, r_out, dbz);
        end
        issue(2'b00, 32'hFFFFFFFB, 32'd0, lat, bcyc, ok);
        n_checks++; if (!ok || lat != 1 || q_out !== 32'hFFFFFFFF || r_out !== 32'hFFFFFFFB || dbz !== 1'b1) begin
            n_fail++; $display("FAIL early_dbz: lat=%0d q=%h r=%h dbz=%b want 1 ffffffff fffffffb 1", lat, q_out, r_out, dbz);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_divu_latency();
        test_signed();
        test_overflow();
        test_div_by_zero();
        test_reset_mid_loop();
        test_back_to_back();
`ifdef DIV_EARLY_OUT_EN
        test_early();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
